stopwatch_7seg: RTL and testbench
=================================

Name: stopwatch_7seg

Overview:
- Consumes the slow square wave from the upstream clock divider (1 Hz on Basys-3) and runs an MM:SS stopwatch in BCD.
- Drives the 4-digit multiplexed seven-segment display; segments and anodes are active-low.
- The divided clock is treated as data only. It is synchronised and edge-detected into a one-cycle tick on clk_in and never used as a clock.

Parameters:
- REFRESH_DIV, 27'd100000: clk_in cycles per digit slot (1 kHz digit rate at 100 MHz); legal range ≥2.
- SYNC_STAGES, 2: synchroniser depth for tick_in; legal range ≥2.

Ports:
- clk_in  input  1  system clock, 100 MHz
- rst  input  1  asynchronous, active-high reset
- tick_in  input  1  divided clock from upstream divider; rising edge = +1 second
- run  input  1  level; 1 = count, 0 = hold
- clear  input  1  level; synchronous clear of the count
- count_bcd  output  16  {M1,M0,S1,S0}, 4 bits each
- rollover  output  1  one-cycle pulse on the 59:59 -> 00:00 wrap
- an  output  4  digit anodes, active-low, one-hot-low
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- dp  output  1  decimal point, active-low

Behaviour:
- Reset and clock domain:
  - One clock domain, clk_in. rst is asynchronous, active-high.
  - All state is reset asynchronously.
  - Reset values: count_bcd=16'h0000, rollover=0, an=4'b1110, seg=7'b1000000 ("0"), dp=1, synchroniser flops=0, edge register=0, refresh counter=0, digit_sel=0.
- Tick path:
  - tick_in passes through SYNC_STAGES flops, then an edge register.
  - tick_pulse = sync_out & ~edge_q.
  - A rising tick_in first sampled at edge k produces tick_pulse during the cycle after edge k+SYNC_STAGES-1.
  - count_bcd updates at edge k+SYNC_STAGES (default: 2 edges after first sample).
  - Falling edges are ignored.
  - Since reset clears the synchroniser, tick_in=1 during reset produces one tick after rst deasserts. This is accepted.
- Count rules (digit ranges: S0 0-9, S1 0-5, M0 0-9, M1 0-5), evaluated in this priority order:
  1. clear=1: count_bcd <= 0 and rollover <= 0, regardless of run or tick.
  2. tick_pulse & run: increment with BCD carry.
     - S0 9->0 carries into S1; S1 5->0 carries into M0; M0 9->0 carries into M1.
     - 59:59 -> 00:00 with rollover=1 for exactly that cycle.
  3. Otherwise: hold. rollover=0.
- A tick arriving while run=0 is discarded, not queued. run toggling mid-second does not affect a pending edge except through rule 2.
- No illegal BCD value is ever reachable. Decoding of codes 10-15 returns all segments off (7'b1111111).
- Display multiplex:
  - The refresh counter counts 0..REFRESH_DIV-1 and wraps. On wrap, digit_sel (2 bits) increments modulo 4.
  - digit_sel mapping: 0->S0/an=1110, 1->S1/an=1101, 2->M0/an=1011, 3->M1/an=0111.
  - seg = decode(selected digit). dp=0 only when digit_sel==2 (colon position); otherwise dp=1.
  - an, seg and dp are registered: they reflect the digit_sel and count_bcd values from the previous cycle, one cycle of latency.
  - Exactly one an bit is low at all times after reset. No blank or overlap cycle is required.
- Reset mid-operation: all outputs return to their reset values immediately (asynchronous). Counting resumes from 00:00 on the next accepted tick.

Decomposition:
- Package stopwatch_pkg:
  - Constants SEG_0..SEG_9 and SEG_BLANK (7-bit active-low).
  - AN_DIGIT0..3 (4-bit active-low).
  - BCD_MAX_UNITS=4'd9, BCD_MAX_TENS=4'd5.
- One sub-module, seg7_decoder: combinational 4-bit BCD -> 7-bit active-low segments. It is instantiated once on the muxed digit.
- Synchroniser, edge detect, BCD counter and multiplex logic stay in the top module.

Test Plan (REFRESH_DIV=4 in simulation):
- Reset and tick latency: hold rst 3 cycles, then run=1 and one tick_in rise -> count_bcd=16'h0001 exactly 2 edges after first sample; an=1110, seg=7'b1000000, dp=1 during reset.
- Carry chain: preload 9 ticks, then 1 more tick -> 16'h0010. From 00:59 (16'h0059), 1 tick -> 16'h0100, rollover stays 0.
- Wrap: from 16'h5959, 1 tick -> 16'h0000 with rollover=1 for exactly one cycle.
- Hold and clear priority: run=0 with 3 ticks -> count unchanged. clear=1 coincident with a tick at 16'h0042 -> 16'h0000 and no increment.
- Multiplex: count 16'h1234 -> an sequence 1110, 1101, 1011, 0111, each held 4 cycles.
  - seg values in order: "4"=7'b0011001, "3"=7'b0110000, "2"=7'b0100100, "1"=7'b1111001.
  - dp=0 only while an=1011.
- Async reset mid-count: assert rst between clk_in edges at 16'h0317 -> outputs take reset values before the next edge; after release, the next tick gives 16'h0001.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared constants and types for the MM:SS stopwatch and its seven-segment display.
package stopwatch_pkg;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_DIGIT0 = 4'b1110;
  localparam logic [3:0] AN_DIGIT1 = 4'b1101;
  localparam logic [3:0] AN_DIGIT2 = 4'b1011;
  localparam logic [3:0] AN_DIGIT3 = 4'b0111;

  localparam logic [3:0] BCD_MAX_UNITS = 4'd9;
  localparam logic [3:0] BCD_MAX_TENS  = 4'd5;

  typedef struct packed {
    logic [3:0] m1;
    logic [3:0] m0;
    logic [3:0] s1;
    logic [3:0] s0;
  } bcd_time_t;

  typedef enum logic [1:0] {
    DIG_S0 = 2'd0,
    DIG_S1 = 2'd1,
    DIG_M0 = 2'd2,
    DIG_M1 = 2'd3
  } digit_sel_t;

  function automatic logic [3:0] anode_for(input digit_sel_t sel);
    logic [3:0] result;
    result = AN_DIGIT0;
    case (sel)
      DIG_S0:  result = AN_DIGIT0;
      DIG_S1:  result = AN_DIGIT1;
      DIG_M0:  result = AN_DIGIT2;
      DIG_M1:  result = AN_DIGIT3;
      default: result = AN_DIGIT0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to active-low seven-segment pattern; codes 10-15 blank.
module seg7_decoder
  import stopwatch_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/stopwatch_7seg.sv
// MM:SS BCD stopwatch advanced by a synchronised slow tick, driving a
// 4-digit multiplexed active-low seven-segment display.
module stopwatch_7seg
  import stopwatch_pkg::*;
#(
  parameter logic [26:0] REFRESH_DIV = 27'd100000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        tick_in,
  input  logic        run,
  input  logic        clear,
  output logic [15:0] count_bcd,
  output logic        rollover,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   edge_reg;
  logic                   sync_out;
  logic                   tick_pulse;

  bcd_time_t  time_reg, time_next;
  logic       rollover_reg, rollover_next;

  logic [26:0] refresh_reg;
  logic        refresh_wrap;
  digit_sel_t  digit_sel_reg;

  logic [3:0] digit_mux;
  logic [6:0] seg_dec;
  logic [3:0] an_reg;
  logic [6:0] seg_reg;
  logic       dp_reg;

  // The divided clock is only ever sampled as data.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync_reg <= '0;
      edge_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], tick_in};
      edge_reg <= sync_out;
    end
  end

  assign sync_out   = sync_reg[SYNC_STAGES-1];
  assign tick_pulse = sync_out & ~edge_reg;

  always_comb begin
    time_next     = time_reg;
    rollover_next = 1'b0;
    if (clear) begin
      time_next = '0;
    end else if (tick_pulse && run) begin
      if (time_reg.s0 != BCD_MAX_UNITS) begin
        time_next.s0 = time_reg.s0 + 4'd1;
      end else begin
        time_next.s0 = 4'd0;
        if (time_reg.s1 != BCD_MAX_TENS) begin
          time_next.s1 = time_reg.s1 + 4'd1;
        end else begin
          time_next.s1 = 4'd0;
          if (time_reg.m0 != BCD_MAX_UNITS) begin
            time_next.m0 = time_reg.m0 + 4'd1;
          end else begin
            time_next.m0 = 4'd0;
            if (time_reg.m1 != BCD_MAX_TENS) begin
              time_next.m1 = time_reg.m1 + 4'd1;
            end else begin
              time_next.m1  = 4'd0;
              rollover_next = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      time_reg     <= '0;
      rollover_reg <= 1'b0;
    end else begin
      time_reg     <= time_next;
      rollover_reg <= rollover_next;
    end
  end

  assign refresh_wrap = (refresh_reg == REFRESH_DIV - 27'd1);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      refresh_reg   <= '0;
      digit_sel_reg <= DIG_S0;
    end else if (refresh_wrap) begin
      refresh_reg   <= '0;
      digit_sel_reg <= digit_sel_t'(digit_sel_reg + 2'd1);
    end else begin
      refresh_reg   <= refresh_reg + 27'd1;
    end
  end

  always_comb begin
    digit_mux = time_reg.s0;
    case (digit_sel_reg)
      DIG_S0:  digit_mux = time_reg.s0;
      DIG_S1:  digit_mux = time_reg.s1;
      DIG_M0:  digit_mux = time_reg.m0;
      DIG_M1:  digit_mux = time_reg.m1;
      default: digit_mux = time_reg.s0;
    endcase
  end

  seg7_decoder u_decoder (
    .bcd (digit_mux),
    .seg (seg_dec)
  );

  // Registered display drive; the colon dot sits on the M0 digit.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      an_reg  <= AN_DIGIT0;
      seg_reg <= SEG_0;
      dp_reg  <= 1'b1;
    end else begin
      an_reg  <= anode_for(digit_sel_reg);
      seg_reg <= seg_dec;
      dp_reg  <= (digit_sel_reg != DIG_M0);
    end
  end

  assign count_bcd = time_reg;
  assign rollover  = rollover_reg;
  assign an        = an_reg;
  assign seg       = seg_reg;
  assign dp        = dp_reg;

endmodule

// File: tb/tb_stopwatch_7seg.sv
// Self-checking bench for stopwatch_7seg: the expected time is kept as a plain
// count of seconds and converted to MM:SS digits only for comparison.
module tb_stopwatch_7seg;

  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic        tick_in = 1'b0;
  logic        run = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] count_bcd;
  logic        rollover;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int vectors = 0;
  int miscompares = 0;
  int sec_model = 0;
  int roll_cnt = 0;
  int roll_expected = 0;
  logic [6:0] seg_tab [10];

  stopwatch_7seg #(
    .REFRESH_DIV (27'd4),
    .SYNC_STAGES (2)
  ) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .tick_in   (tick_in),
    .run       (run),
    .clear     (clear),
    .count_bcd (count_bcd),
    .rollover  (rollover),
    .an        (an),
    .seg       (seg),
    .dp        (dp)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [15:0] to_bcd(input int s);
    int m, r;
    m = s / 60;
    r = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(r / 10), 4'(r % 10)};
  endfunction

  task automatic step();
    @(posedge clk_in);
    #1;
    if (rollover === 1'b1) roll_cnt++;
  endtask

  // One full tick_in period; the model advances by the rules on the levels held.
  task automatic send_tick();
    tick_in = 1'b1;
    step();
    step();
    tick_in = 1'b0;
    step();
    step();
    if (clear) sec_model = 0;
    else if (run) begin
      if (sec_model == 3599) roll_expected++;
      sec_model = (sec_model + 1) % 3600;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick_in = 1'b0;
    clear = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    sec_model = 0;
    roll_cnt = 0;
    roll_expected = 0;
  endtask

  task automatic preload(input int n);
    run = 1'b1;
    repeat (n) send_tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    vectors++; if (count_bcd !== 16'h0000) begin miscompares++; $display("FAIL reset_count: got %h expected 0000", count_bcd); end
    vectors++; if (rollover !== 1'b0) begin miscompares++; $display("FAIL reset_rollover: got %b expected 0", rollover); end
    vectors++; if (an !== 4'b1110) begin miscompares++; $display("FAIL reset_an: got %b expected 1110", an); end
    vectors++; if (seg !== 7'b1000000) begin miscompares++; $display("FAIL reset_seg: got %b expected 1000000", seg); end
    vectors++; if (dp !== 1'b1) begin miscompares++; $display("FAIL reset_dp: got %b expected 1", dp); end
    rst = 1'b0;
    step();
    $display("test_reset: count=%h an=%b seg=%b dp=%b", count_bcd, an, seg, dp);
  endtask

  task automatic test_latency();
    run = 1'b1;
    tick_in = 1'b1;
    step();  // first sampling edge
    vectors++; if (count_bcd !== 16'h0000) begin miscompares++; $display("FAIL latency_edge0: got %h expected 0000", count_bcd); end
    step();
    vectors++; if (count_bcd !== 16'h0000) begin miscompares++; $display("FAIL latency_edge1: got %h expected 0000", count_bcd); end
    step();
    vectors++; if (count_bcd !== 16'h0001) begin miscompares++; $display("FAIL latency_edge2: got %h expected 0001", count_bcd); end
    tick_in = 1'b0;
    step();
    step();
    vectors++; if (count_bcd !== 16'h0001) begin miscompares++; $display("FAIL latency_single: got %h expected 0001", count_bcd); end
    sec_model = 1;
    $display("test_latency: count=%h", count_bcd);
  endtask

  task automatic test_carry();
    do_reset();
    preload(9);
    vectors++; if (count_bcd !== to_bcd(sec_model)) begin miscompares++; $display("FAIL carry_9: got %h expected %h", count_bcd, to_bcd(sec_model)); end
    send_tick();
    vectors++; if (count_bcd !== 16'h0010) begin miscompares++; $display("FAIL carry_s0: got %h expected 0010", count_bcd); end
    preload(49);
    vectors++; if (count_bcd !== 16'h0059) begin miscompares++; $display("FAIL carry_0059: got %h expected 0059", count_bcd); end
    send_tick();
    vectors++; if (count_bcd !== 16'h0100) begin miscompares++; $display("FAIL carry_s1: got %h expected 0100", count_bcd); end
    vectors++; if (roll_cnt !== 0) begin miscompares++; $display("FAIL carry_rollover: got %0d pulses expected 0", roll_cnt); end
    $display("test_carry: count=%h rollover_pulses=%0d", count_bcd, roll_cnt);
  endtask

  task automatic test_wrap();
    do_reset();
    preload(3599);
    vectors++; if (count_bcd !== 16'h5959) begin miscompares++; $display("FAIL wrap_preload: got %h expected 5959", count_bcd); end
    roll_cnt = 0;
    tick_in = 1'b1;
    step();
    step();
    vectors++; if (rollover !== 1'b0) begin miscompares++; $display("FAIL wrap_pre_roll: got %b expected 0", rollover); end
    step();
    vectors++; if (count_bcd !== 16'h0000) begin miscompares++; $display("FAIL wrap_count: got %h expected 0000", count_bcd); end
    vectors++; if (rollover !== 1'b1) begin miscompares++; $display("FAIL wrap_roll: got %b expected 1", rollover); end
    tick_in = 1'b0;
    step();
    vectors++; if (rollover !== 1'b0) begin miscompares++; $display("FAIL wrap_roll_after: got %b expected 0", rollover); end
    step();
    vectors++; if (roll_cnt !== 1) begin miscompares++; $display("FAIL wrap_roll_width: got %0d cycles expected 1", roll_cnt); end
    sec_model = 0;
    $display("test_wrap: count=%h rollover_cycles=%0d", count_bcd, roll_cnt);
  endtask

  task automatic test_hold_clear();
    do_reset();
    preload(42);
    vectors++; if (count_bcd !== 16'h0042) begin miscompares++; $display("FAIL hold_preload: got %h expected 0042", count_bcd); end
    run = 1'b0;
    repeat (3) send_tick();
    vectors++; if (count_bcd !== 16'h0042) begin miscompares++; $display("FAIL hold_count: got %h expected 0042", count_bcd); end
    run = 1'b1;
    clear = 1'b1;
    send_tick();
    clear = 1'b0;
    vectors++; if (count_bcd !== 16'h0000) begin miscompares++; $display("FAIL clear_priority: got %h expected 0000", count_bcd); end
    step();
    step();
    vectors++; if (count_bcd !== 16'h0000) begin miscompares++; $display("FAIL clear_no_late_inc: got %h expected 0000", count_bcd); end
    send_tick();
    vectors++; if (count_bcd !== 16'h0001) begin miscompares++; $display("FAIL clear_resume: got %h expected 0001", count_bcd); end
    $display("test_hold_clear: count=%h", count_bcd);
  endtask

  task automatic test_mux(input int target);
    int d[4];
    int m, r;
    bit found;
    logic [3:0] prev_an;
    do_reset();
    preload(target);
    run = 1'b0;
    m = sec_model / 60;
    r = sec_model % 60;
    d[0] = r % 10;
    d[1] = r / 10;
    d[2] = m % 10;
    d[3] = m / 10;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      prev_an = an;
      step();
      if (prev_an === 4'b0111 && an === 4'b1110) found = 1'b1;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL mux_sync: got no 0111->1110 transition within 40 cycles, last an=%b", an);
    end else begin
      for (int i = 0; i < 16; i++) begin
        int slot;
        logic [3:0] exp_an;
        logic exp_dp;
        slot = i / 4;
        exp_an = 4'b1111 & ~(4'b0001 << slot);
        exp_dp = (slot == 2) ? 1'b0 : 1'b1;
        vectors++; if (an !== exp_an) begin miscompares++; $display("FAIL mux_an: cycle %0d got %b expected %b", i, an, exp_an); end
        vectors++; if (seg !== seg_tab[d[slot]]) begin miscompares++; $display("FAIL mux_seg: cycle %0d got %b expected %b", i, seg, seg_tab[d[slot]]); end
        vectors++; if (dp !== exp_dp) begin miscompares++; $display("FAIL mux_dp: cycle %0d got %b expected %b", i, dp, exp_dp); end
        step();
      end
    end
    $display("test_mux: count=%h digits %0d%0d:%0d%0d", count_bcd, d[3], d[2], d[1], d[0]);
  endtask

  task automatic test_async_reset();
    do_reset();
    preload(197);
    vectors++; if (count_bcd !== 16'h0317) begin miscompares++; $display("FAIL async_preload: got %h expected 0317", count_bcd); end
    @(posedge clk_in);
    #3;
    rst = 1'b1;
    #1;
    vectors++; if (count_bcd !== 16'h0000) begin miscompares++; $display("FAIL async_count: got %h expected 0000", count_bcd); end
    vectors++; if (rollover !== 1'b0) begin miscompares++; $display("FAIL async_rollover: got %b expected 0", rollover); end
    vectors++; if (an !== 4'b1110) begin miscompares++; $display("FAIL async_an: got %b expected 1110", an); end
    vectors++; if (seg !== 7'b1000000) begin miscompares++; $display("FAIL async_seg: got %b expected 1000000", seg); end
    vectors++; if (dp !== 1'b1) begin miscompares++; $display("FAIL async_dp: got %b expected 1", dp); end
    step();
    step();
    rst = 1'b0;
    step();
    sec_model = 0;
    run = 1'b1;
    send_tick();
    vectors++; if (count_bcd !== 16'h0001) begin miscompares++; $display("FAIL async_resume: got %h expected 0001", count_bcd); end
    $display("test_async_reset: count=%h", count_bcd);
  endtask

  task automatic test_random();
    do_reset();
    preload($urandom_range(100, 400));
    vectors++; if (count_bcd !== to_bcd(sec_model)) begin miscompares++; $display("FAIL rand_preload: got %h expected %h", count_bcd, to_bcd(sec_model)); end
    for (int t = 0; t < 40; t++) begin
      run = ($urandom_range(0, 3) != 0);
      clear = ($urandom_range(0, 9) == 0);
      send_tick();
      clear = 1'b0;
      repeat ($urandom_range(0, 3)) step();
      vectors++;
      if (count_bcd !== to_bcd(sec_model)) begin
        miscompares++;
        $display("FAIL rand_count: txn %0d got %h expected %h", t, count_bcd, to_bcd(sec_model));
      end
      $display("rand txn %0d: run=%b count=%h model=%h", t, run, count_bcd, to_bcd(sec_model));
    end
    vectors++; if (roll_cnt !== roll_expected) begin miscompares++; $display("FAIL rand_rollover: got %0d pulses expected %0d", roll_cnt, roll_expected); end
  endtask

  initial begin
    seg_tab[0] = 7'b1000000;
    seg_tab[1] = 7'b1111001;
    seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000;
    seg_tab[4] = 7'b0011001;
    seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010;
    seg_tab[7] = 7'b1111000;
    seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;

    test_reset();
    test_latency();
    test_carry();
    test_wrap();
    test_hold_clear();
    test_mux(754);   // 12:34
    test_mux(486);   // 08:06
    test_async_reset();
    test_random();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
